// File: rtl/spi_reg_slave.sv
// spi_reg_slave: SPI mode-0 responder exposing a small 8-bit register bank.
// Byte 0 is a command (bit 7 = read, low bits = start address), and the
// following bytes are written to or read from consecutive registers, with the
// address wrapping at the top of the bank. SCLK, SS_N and MOSI are sampled on
// the system clock through 2-flop synchronizers.
module spi_reg_slave #(
  parameter int unsigned ADDR_W  = 3,
  parameter logic [7:0]  RST_VAL = 8'h00,
  localparam int unsigned NREGS  = 2 ** ADDR_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sclk,
  input  logic                 ss_n,
  input  logic                 mosi,
  output logic                 miso,
  output logic [8*NREGS-1:0]   regs_o,
  output logic                 wr_strobe,
  output logic [ADDR_W-1:0]    wr_addr,
  output logic [7:0]           wr_data,
  output logic                 busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CMD     = 2'd1,
    DATA_WR = 2'd2,
    DATA_RD = 2'd3
  } state_t;

  // synchronizer and edge-detect history
  logic sclkMeta_q, sclkSync_q, sclkPrev_q;
  logic ssMeta_q, ssSync_q, ssPrev_q;
  logic mosiMeta_q, mosiSync_q;

  logic sclkRise, sclkFall, ssFall, ssRise;

  // protocol state
  state_t            state_q, state_d;
  logic [2:0]        bitCnt_q, bitCnt_d;
  logic [7:0]        rxShift_q, rxShift_d;
  logic [7:0]        txShift_q, txShift_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              miso_q, miso_d;
  logic [7:0]        rxByte;

  // write request scheduled in the detect cycle, committed on the next edge
  logic              wrEn_d;
  logic [ADDR_W-1:0] wrAddr_d;
  logic [7:0]        wrData_d;

  // register bank and write-report outputs
  logic [7:0]        regs_q [NREGS];
  logic              wrStrobe_q;
  logic [ADDR_W-1:0] wrAddr_q;
  logic [7:0]        wrData_q;

  // Two-flop synchronizers plus one extra stage for edge detection. The
  // ss_n chain resets to "selected" so that a master still holding ss_n low
  // across a reset does not create a false falling edge and restart mid-frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      sclkMeta_q <= 1'b0;
      sclkSync_q <= 1'b0;
      sclkPrev_q <= 1'b0;
      ssMeta_q   <= 1'b0;
      ssSync_q   <= 1'b0;
      ssPrev_q   <= 1'b0;
      mosiMeta_q <= 1'b0;
      mosiSync_q <= 1'b0;
    end else begin
      sclkMeta_q <= sclk;
      sclkSync_q <= sclkMeta_q;
      sclkPrev_q <= sclkSync_q;
      ssMeta_q   <= ss_n;
      ssSync_q   <= ssMeta_q;
      ssPrev_q   <= ssSync_q;
      mosiMeta_q <= mosi;
      mosiSync_q <= mosiMeta_q;
    end
  end

  assign sclkRise = sclkSync_q & ~sclkPrev_q;
  assign sclkFall = ~sclkSync_q & sclkPrev_q;
  assign ssFall   = ssPrev_q & ~ssSync_q;
  assign ssRise   = ~ssPrev_q & ssSync_q;
  assign rxByte   = {rxShift_q[6:0], mosiSync_q};

  // Next-state logic: command decode, byte assembly, read shifting and
  // write scheduling; deselect overrides everything and drops partial bytes.
  always_comb begin
    state_d   = state_q;
    bitCnt_d  = bitCnt_q;
    rxShift_d = rxShift_q;
    txShift_d = txShift_q;
    addr_d    = addr_q;
    wrEn_d    = 1'b0;
    wrAddr_d  = addr_q;
    wrData_d  = rxByte;

    case (state_q)
      IDLE: begin
        txShift_d = 8'h00;
        if (ssFall) begin
          state_d   = CMD;
          bitCnt_d  = 3'd0;
          rxShift_d = 8'h00;
        end
      end

      CMD: begin
        if (sclkRise) begin
          rxShift_d = rxByte;
          bitCnt_d  = bitCnt_q + 3'd1;
          if (bitCnt_q == 3'd7) begin
            addr_d  = rxByte[ADDR_W-1:0];
            state_d = rxByte[7] ? DATA_RD : DATA_WR;
          end
        end
      end

      DATA_WR: begin
        if (sclkRise) begin
          rxShift_d = rxByte;
          bitCnt_d  = bitCnt_q + 3'd1;
          if (bitCnt_q == 3'd7) begin
            wrEn_d = 1'b1;
            addr_d = addr_q + ADDR_W'(1);
          end
        end
      end

      DATA_RD: begin
        if (sclkRise) begin
          bitCnt_d = bitCnt_q + 3'd1;
        end else if (sclkFall) begin
          if (bitCnt_q == 3'd0) begin
            txShift_d = regs_q[addr_q];
            addr_d    = addr_q + ADDR_W'(1);
          end else begin
            txShift_d = {txShift_q[6:0], 1'b0};
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    if (state_q != IDLE && ssRise) begin
      state_d   = IDLE;
      bitCnt_d  = 3'd0;
      txShift_d = 8'h00;
      wrEn_d    = 1'b0;
    end

    miso_d = (state_d == DATA_RD) ? txShift_d[7] : 1'b0;
  end

  // Protocol state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      bitCnt_q  <= 3'd0;
      rxShift_q <= 8'h00;
      txShift_q <= 8'h00;
      addr_q    <= '0;
      miso_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bitCnt_q  <= bitCnt_d;
      rxShift_q <= rxShift_d;
      txShift_q <= txShift_d;
      addr_q    <= addr_d;
      miso_q    <= miso_d;
    end
  end

  // Register bank update and write report; both appear on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NREGS; k++) begin
        regs_q[k] <= RST_VAL;
      end
      wrStrobe_q <= 1'b0;
      wrAddr_q   <= '0;
      wrData_q   <= 8'h00;
    end else begin
      wrStrobe_q <= wrEn_d;
      if (wrEn_d) begin
        regs_q[wrAddr_d] <= wrData_d;
        wrAddr_q         <= wrAddr_d;
        wrData_q         <= wrData_d;
      end
    end
  end

  // Flatten the bank onto the output bus, register k at bits [8k+7:8k].
  always_comb begin
    regs_o = '0;
    for (int k = 0; k < NREGS; k++) begin
      regs_o[8*k +: 8] = regs_q[k];
    end
  end

  assign miso      = miso_q;
  assign wr_strobe = wrStrobe_q;
  assign wr_addr   = wrAddr_q;
  assign wr_data   = wrData_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_spi_reg_slave.sv
// tb_spi_reg_slave: drives spi_reg_slave as an SPI mode-0 master. Expected
// writes and expected MISO bytes are queued as stimulus is issued; monitor
// processes pop and compare when the DUT strobes a write or a byte completes.
module tb_spi_reg_slave;

  localparam int ADDR_W = 3;
  localparam int NREGS  = 8;
  localparam int HALF   = 8;

  logic                clk  = 1'b0;
  logic                rst  = 1'b1;
  logic                sclk = 1'b0;
  logic                ss_n = 1'b1;
  logic                mosi = 1'b0;
  logic                miso;
  logic [8*NREGS-1:0]  regs_o;
  logic                wr_strobe;
  logic [ADDR_W-1:0]   wr_addr;
  logic [7:0]          wr_data;
  logic                busy;

  int total = 0;
  int bad   = 0;

  logic [7:0]  expRegs [NREGS];
  logic [10:0] expWrQ [$];
  logic [7:0]  expMisoQ [$];
  logic [10:0] expW;
  logic [7:0]  expM;
  logic        prevStrobe = 1'b0;
  logic [7:0]  misoSh = 8'h00;
  int          misoCnt = 0;

  spi_reg_slave #(
    .ADDR_W (ADDR_W),
    .RST_VAL(8'h00)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .sclk     (sclk),
    .ss_n     (ss_n),
    .mosi     (mosi),
    .miso     (miso),
    .regs_o   (regs_o),
    .wr_strobe(wr_strobe),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .busy     (busy)
  );

  // free-running system clock
  always #5 clk = ~clk;

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic waitClk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic resetDut();
    rst = 1'b1;
    waitClk(2);
    rst = 1'b0;
    for (int k = 0; k < NREGS; k++) expRegs[k] = 8'h00;
  endtask

  task automatic selectSlave();
    waitClk(HALF);
    ss_n = 1'b0;
    waitClk(HALF);
  endtask

  task automatic deselectSlave();
    waitClk(HALF);
    ss_n = 1'b1;
    mosi = 1'b0;
    waitClk(2 * HALF);
  endtask

  task automatic expectWrite(input logic [ADDR_W-1:0] addr, input logic [7:0] data);
    expRegs[addr] = data;
    expWrQ.push_back({addr, data});
  endtask

  // shift out the top nbits of data, MSB first; a full byte queues the
  // byte the master should receive on MISO
  task automatic applyStimulus(input logic [7:0] data, input int nbits, input logic [7:0] expMiso);
    if (nbits == 8) expMisoQ.push_back(expMiso);
    for (int i = 7; i > 7 - nbits; i--) begin
      mosi = data[i];
      waitClk(HALF);
      sclk = 1'b1;
      waitClk(HALF);
      sclk = 1'b0;
    end
  endtask

  task automatic checkOutput(input string tag, input logic expBusy);
    for (int k = 0; k < NREGS; k++) begin
      checkVal($sformatf("%s_reg%0d", tag, k), {24'h0, regs_o[8*k +: 8]}, {24'h0, expRegs[k]});
    end
    checkVal({tag, "_busy"}, {31'h0, busy}, {31'h0, expBusy});
    checkVal({tag, "_miso"}, {31'h0, miso}, 32'h0);
    checkVal({tag, "_strobe"}, {31'h0, wr_strobe}, 32'h0);
  endtask

  // write monitor: every strobe must match the next queued write and never
  // appear on two consecutive cycles
  always @(negedge clk) begin
    if (wr_strobe === 1'b1) begin
      checkVal("strobe_gap", {31'h0, prevStrobe}, 32'h0);
      if (expWrQ.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL unexpected_strobe: got addr %0h data %0h, expected no strobe", wr_addr, wr_data);
      end else begin
        expW = expWrQ.pop_front();
        checkVal("wr_addr", {29'h0, wr_addr}, {29'h0, expW[10:8]});
        checkVal("wr_data", {24'h0, wr_data}, {24'h0, expW[7:0]});
      end
    end
    prevStrobe = wr_strobe;
  end

  // MISO monitor: assemble bytes at master sampling edges, restart on deselect
  always @(posedge sclk or posedge ss_n) begin
    if (ss_n) begin
      misoCnt = 0;
    end else begin
      misoSh = {misoSh[6:0], miso};
      misoCnt++;
      if (misoCnt == 8) begin
        misoCnt = 0;
        if (expMisoQ.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL unexpected_miso_byte: got %0h, expected none", misoSh);
        end else begin
          expM = expMisoQ.pop_front();
          checkVal("miso_byte", {24'h0, misoSh}, {24'h0, expM});
        end
      end
    end
  end

  // watchdog so the run always ends
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    for (int k = 0; k < NREGS; k++) expRegs[k] = 8'h00;
    $display("[TB] starting spi_reg_slave test");

    resetDut();
    checkOutput("reset", 1'b0);

    // single write
    selectSlave();
    applyStimulus(8'h03, 8, 8'h00);
    expectWrite(3'd3, 8'h5A);
    applyStimulus(8'h5A, 8, 8'h00);
    deselectSlave();
    checkOutput("wr1", 1'b0);

    // single read
    selectSlave();
    applyStimulus(8'h83, 8, 8'h00);
    applyStimulus(8'h00, 8, 8'h5A);
    deselectSlave();
    checkOutput("rd1", 1'b0);

    // burst write wrapping from 7 to 0
    selectSlave();
    applyStimulus(8'h06, 8, 8'h00);
    checkOutput("burst_mid", 1'b1);
    expectWrite(3'd6, 8'h11);
    applyStimulus(8'h11, 8, 8'h00);
    expectWrite(3'd7, 8'h22);
    applyStimulus(8'h22, 8, 8'h00);
    expectWrite(3'd0, 8'h33);
    applyStimulus(8'h33, 8, 8'h00);
    deselectSlave();
    checkOutput("burst_wr", 1'b0);

    // burst read across the wrap; dummy MOSI bytes must be ignored
    selectSlave();
    applyStimulus(8'h86, 8, 8'h00);
    applyStimulus(8'h00, 8, 8'h11);
    applyStimulus(8'hFF, 8, 8'h22);
    applyStimulus(8'h00, 8, 8'h33);
    deselectSlave();
    checkOutput("burst_rd", 1'b0);

    // aborted partial byte, then a full write to the same register
    selectSlave();
    applyStimulus(8'h01, 8, 8'h00);
    applyStimulus(8'hFF, 5, 8'h00);
    deselectSlave();
    checkOutput("abort", 1'b0);
    selectSlave();
    applyStimulus(8'h01, 8, 8'h00);
    expectWrite(3'd1, 8'hA5);
    applyStimulus(8'hA5, 8, 8'h00);
    deselectSlave();
    checkOutput("after_abort", 1'b0);

    // reset in the middle of the second data byte of a burst
    selectSlave();
    applyStimulus(8'h02, 8, 8'h00);
    expectWrite(3'd2, 8'h3C);
    applyStimulus(8'h3C, 8, 8'h00);
    fork
      applyStimulus(8'hC3, 8, 8'h00);
      begin
        waitClk(40);
        resetDut();
      end
    join
    applyStimulus(8'h77, 8, 8'h00);
    deselectSlave();
    checkOutput("rst_mid", 1'b0);

    // normal traffic after the interrupted transaction
    selectSlave();
    applyStimulus(8'h05, 8, 8'h00);
    expectWrite(3'd5, 8'h9C);
    applyStimulus(8'h9C, 8, 8'h00);
    deselectSlave();
    selectSlave();
    applyStimulus(8'h85, 8, 8'h00);
    applyStimulus(8'h00, 8, 8'h9C);
    deselectSlave();
    checkOutput("post_rst", 1'b0);

    waitClk(4);
    checkVal("wr_queue_empty", expWrQ.size(), 32'd0);
    checkVal("miso_queue_empty", expMisoQ.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
